// File: rtl/baud_rate_gen_if.sv
// Control and tick signals of the fractional baud-rate generator.
// The controller drives the master side; the generator uses the slave side.
interface baud_rate_gen_if #(
  parameter int DIV_W  = 16,
  parameter int FRAC_W = 4
);
  logic              enb;
  logic              clear;
  logic [DIV_W-1:0]  div_int;
  logic [FRAC_W-1:0] div_frac;
  logic              div_load;
  logic              os_tick;
  logic              mid_tick;
  logic              bit_tick;
  logic              cfg_err;
  logic              load_pend;

  modport master (
    output enb, clear, div_int, div_frac, div_load,
    input  os_tick, mid_tick, bit_tick, cfg_err, load_pend
  );

  modport slave (
    input  enb, clear, div_int, div_frac, div_load,
    output os_tick, mid_tick, bit_tick, cfg_err, load_pend
  );
endinterface

// File: rtl/baud_rate_gen.sv
// Fractional-N baud-rate generator: prescaler with fractional carry feeding
// an oversample counter that marks bit centre and bit end.
module baud_rate_gen #(
  parameter int DIV_W   = 16,
  parameter int FRAC_W  = 4,
  parameter int OS_RATE = 16
) (
  input  logic           clk,
  input  logic           rst,
  baud_rate_gen_if.slave bus
);
  localparam int OS_W = (OS_RATE > 2) ? $clog2(OS_RATE) : 1;

  logic [DIV_W-1:0]  act_int_reg, act_int_next;
  logic [FRAC_W-1:0] act_frac_reg, act_frac_next;
  logic [DIV_W-1:0]  pend_int_reg, pend_int_next;
  logic [FRAC_W-1:0] pend_frac_reg, pend_frac_next;
  logic              pend_reg, pend_next;
  logic [DIV_W-1:0]  pre_cnt_reg, pre_cnt_next;
  logic [FRAC_W-1:0] frac_acc_reg, frac_acc_next;
  logic              carry_reg, carry_next;
  logic [OS_W-1:0]   os_cnt_reg, os_cnt_next;

  logic              run;
  logic              os_tick;
  logic              mid_tick;
  logic              bit_tick;
  logic              apply;
  logic [DIV_W:0]    limit;
  logic [DIV_W:0]    pre_inc;
  logic [FRAC_W:0]   frac_sum;

  // Gating on rst keeps every tick low while reset is held, even with enb high.
  assign run      = rst && bus.enb && !bus.clear && (act_int_reg != '0);
  assign limit    = {1'b0, act_int_reg} + {{DIV_W{1'b0}}, carry_reg};
  assign pre_inc  = {1'b0, pre_cnt_reg} + (DIV_W+1)'(1);
  // ">=" rather than "==" so a divisor shrunk below pre_cnt still wraps.
  assign os_tick  = run && (pre_inc >= limit);
  assign mid_tick = os_tick && (os_cnt_reg == OS_W'(OS_RATE/2 - 1));
  assign bit_tick = os_tick && (os_cnt_reg == OS_W'(OS_RATE - 1));
  assign frac_sum = {1'b0, frac_acc_reg} + {1'b0, act_frac_reg};

  assign bus.os_tick   = os_tick;
  assign bus.mid_tick  = mid_tick;
  assign bus.bit_tick  = bit_tick;
  assign bus.cfg_err   = (act_int_reg == '0);
  assign bus.load_pend = pend_reg;

  always_comb begin
    act_int_next   = act_int_reg;
    act_frac_next  = act_frac_reg;
    pend_int_next  = pend_int_reg;
    pend_frac_next = pend_frac_reg;
    pend_next      = pend_reg;
    apply          = 1'b0;
    if (!bus.enb) begin
      if (bus.div_load) begin
        act_int_next  = bus.div_int;
        act_frac_next = bus.div_frac;
      end else if (pend_reg) begin
        act_int_next  = pend_int_reg;
        act_frac_next = pend_frac_reg;
      end
      pend_next = 1'b0;
    end else if (bit_tick) begin
      // A load coinciding with the bit boundary takes effect directly.
      if (bus.div_load) begin
        act_int_next  = bus.div_int;
        act_frac_next = bus.div_frac;
        apply         = 1'b1;
      end else if (pend_reg) begin
        act_int_next  = pend_int_reg;
        act_frac_next = pend_frac_reg;
        apply         = 1'b1;
      end
      pend_next = 1'b0;
    end else if (bus.div_load) begin
      pend_int_next  = bus.div_int;
      pend_frac_next = bus.div_frac;
      pend_next      = 1'b1;
    end
  end

  always_comb begin
    pre_cnt_next  = pre_cnt_reg;
    frac_acc_next = frac_acc_reg;
    carry_next    = carry_reg;
    os_cnt_next   = os_cnt_reg;
    if (!run) begin
      pre_cnt_next  = '0;
      frac_acc_next = '0;
      carry_next    = 1'b0;
      os_cnt_next   = '0;
    end else if (os_tick) begin
      pre_cnt_next = '0;
      os_cnt_next  = bit_tick ? '0 : os_cnt_reg + OS_W'(1);
      if (apply) begin
        frac_acc_next = '0;
        carry_next    = 1'b0;
      end else begin
        {carry_next, frac_acc_next} = frac_sum;
      end
    end else begin
      pre_cnt_next = pre_cnt_reg + DIV_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      act_int_reg   <= DIV_W'(1);
      act_frac_reg  <= '0;
      pend_int_reg  <= '0;
      pend_frac_reg <= '0;
      pend_reg      <= 1'b0;
      pre_cnt_reg   <= '0;
      frac_acc_reg  <= '0;
      carry_reg     <= 1'b0;
      os_cnt_reg    <= '0;
    end else begin
      act_int_reg   <= act_int_next;
      act_frac_reg  <= act_frac_next;
      pend_int_reg  <= pend_int_next;
      pend_frac_reg <= pend_frac_next;
      pend_reg      <= pend_next;
      pre_cnt_reg   <= pre_cnt_next;
      frac_acc_reg  <= frac_acc_next;
      carry_reg     <= carry_next;
      os_cnt_reg    <= os_cnt_next;
    end
  end
endmodule

// File: doc/baud_rate_gen.md
BAUD_RATE_GEN -- requirements
Module: baud_rate_gen

Interface
REQ-001 SHALL have parameter DIV_W, default 16, integer-divisor width in bits.
REQ-002 SHALL have parameter FRAC_W, default 4, fractional-divisor width; fraction = div_frac/2^FRAC_W.
REQ-003 SHALL have parameter OS_RATE, default 16, oversample ticks per bit; even, >=2.
REQ-004 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-005 SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port enb  input  1  run enable; low holds all counters at 0.
REQ-007 SHALL have port clear  input  1  synchronous counter clear; priority over enb.
REQ-008 SHALL have port div_int  input  DIV_W  integer clocks per oversample tick.
REQ-009 SHALL have port div_frac  input  FRAC_W  fractional clocks per oversample tick.
REQ-010 SHALL have port div_load  input  1  one-cycle strobe to capture div_int/div_frac.
REQ-011 SHALL have port os_tick  output  1  one-cycle pulse per oversample period.
REQ-012 SHALL have port mid_tick  output  1  one-cycle pulse at bit centre (RX sample point).
REQ-013 SHALL have port bit_tick  output  1  one-cycle pulse at bit end (TX shift / RX bit done).
REQ-014 SHALL have port cfg_err  output  1  level: active integer divisor is 0.
REQ-015 SHALL have port load_pend  output  1  level: captured divisor not yet applied.

Function
REQ-016 SHALL keep active divisor act_int/act_frac, pending divisor, pend flag, prescaler pre_cnt (DIV_W), fraction accumulator frac_acc (FRAC_W), carry bit, oversample counter os_cnt (clog2(OS_RATE)).
REQ-017 SHALL, on div_load with enb=0, copy div_int/div_frac to active registers next edge; pend stays 0.
REQ-018 SHALL, on div_load with enb=1, copy inputs to pending registers and set pend; new div_load while pending overwrites pending values.
REQ-019 SHALL apply pending values to active registers on the edge ending a bit_tick cycle, clear pend, and restart pre_cnt, os_cnt, frac_acc, carry from 0.
REQ-020 SHALL, when enb=1 and clear=0 and act_int!=0, increment pre_cnt each cycle; period limit L = act_int + carry.
REQ-021 SHALL assert os_tick combinationally while enb=1, clear=0, act_int!=0 and pre_cnt == L-1.
REQ-022 SHALL, on an os_tick edge: pre_cnt <= 0; {carry, frac_acc} <= frac_acc + act_frac (FRAC_W+1-bit sum); os_cnt wraps OS_RATE-1 -> 0, else +1.
REQ-023 SHALL assert mid_tick = os_tick AND os_cnt == OS_RATE/2-1; bit_tick = os_tick AND os_cnt == OS_RATE-1.
REQ-024 SHALL, with act_int=1 and act_frac=0, assert os_tick every enabled cycle.
REQ-025 SHALL, if pre_cnt >= L-1 at any enabled cycle (divisor reduced externally), treat it as wrap: os_tick asserted, pre_cnt <= 0.
REQ-026 SHALL, when act_int==0, drive cfg_err=1, all ticks 0, hold counters at 0.
REQ-027 SHALL, on enb=0, force pre_cnt, os_cnt, frac_acc, carry to 0 next edge and drive ticks 0; a pending load is applied immediately on the first enb=0 edge.
REQ-028 SHALL, on clear=1, zero pre_cnt, os_cnt, frac_acc, carry next edge with ticks 0 that cycle; active and pending divisors unaffected.
REQ-029 SHALL, on simultaneous div_load and bit_tick, apply the newly presented values directly at that edge.
REQ-030 SHALL drive load_pend from pend; cfg_err from act_int==0.

Reset
REQ-031 SHALL on rst=0, asynchronously: act_int <= 1, act_frac <= 0, pending regs 0, pend 0, pre_cnt/os_cnt/frac_acc/carry 0.
REQ-032 SHALL hold os_tick, mid_tick, bit_tick, load_pend, cfg_err at 0 during and after reset until enb.
REQ-033 SHALL abandon any in-progress bit on reset mid-operation; first tick after release counts from 0.

Verification
REQ-034 SHALL cover: load 4/0 with enb=0, OS_RATE=16, raise enb -> os_tick every 4 cycles (first in cycle 4), mid_tick cycle 32, bit_tick cycle 64, repeat 64.
REQ-035 SHALL cover: load 4/8 (FRAC_W=4) -> os periods 4,4,5,4,5,...; first bit_tick in enabled cycle 71.
REQ-036 SHALL cover: running 4/0, div_load 2/0 in cycle 10 -> load_pend=1 until bit_tick cycle 64, then os_tick every 2 cycles, next bit_tick cycle 96.
REQ-037 SHALL cover: load 0/0 -> cfg_err=1, no ticks for 200 cycles; load 1/0 -> os_tick every cycle, bit_tick every 16.
REQ-038 SHALL cover: clear at cycle 30 of 4/0 run -> ticks 0 that cycle, next os_tick 4 cycles later, bit_tick 64 cycles after clear.
REQ-039 SHALL cover: rst asserted mid-bit (os_cnt=9) -> all outputs 0 immediately, act_int=1 after release.
